// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
//
// Parameterised register file with:
//   * NUM_REGS stored general registers R0..R(NUM_REGS-1),
//   * a virtual PC slot at address PC_IDX = 2^ADDR_W-1,
//   * two registered read ports and one write port,
//   * a 4-bit N,Z,C,V status flag register,
//   * a two-state CLEAR/READY FSM that zeroes one register per cycle after
//     reset or on a soft clear request.
//
// Reading PC_IDX returns the R15 input (PC+8) sampled at the read edge.
// Writing PC_IDX stores nothing; it raises pc_we for one cycle with pc_wd
// holding the written value. Addresses between NUM_REGS and PC_IDX-1 read
// as zero, and writes to them are dropped. The legal range is
// 1 <= NUM_REGS <= PC_IDX.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   A READY-state write to a stored register is forwarded to a read port
//   that addresses the same register at the same edge. Without the macro,
//   such a read returns the old contents and no forwarding logic exists.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   clr_req    in   soft clear request (honoured in READY only)
//   A1, A2     in   read addresses, ports 1 and 2
//   A3         in   write address
//   WD3        in   write data
//   WE3        in   write enable
//   R15        in   PC+8 value returned for reads of PC_IDX
//   flags_we   in   status flag write enable
//   flags_in   in   N,Z,C,V flags to store
//   RD1, RD2   out  registered read data (1-cycle latency)
//   pc_we      out  one-cycle pulse: write to PC_IDX accepted
//   pc_wd      out  data of the last accepted PC write
//   flags_out  out  stored status flags
//   ready      out  1 = READY state, accesses accepted
// ---------------------------------------------------------------------------
module param_register_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   input  logic [DATA_W-1:0] R15,
   input  logic              flags_we,
   input  logic [3:0]        flags_in,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              pc_we,
   output logic [DATA_W-1:0] pc_wd,
   output logic [3:0]        flags_out,
   output logic              ready
);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] PC_IDX   = '1;
   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] regs [NUM_REGS];

   logic              wr_en;
   logic              pc_wr;
   logic [DATA_W-1:0] rd1_next;
   logic [DATA_W-1:0] rd2_next;

   // An access is accepted only in READY and not on the edge that starts a
   // soft clear; the clear sequence owns the array from that edge onward.
   always_comb begin
      wr_en = (state == READY) && !clr_req && WE3;
      pc_wr = wr_en && (A3 == PC_IDX);
   end

`ifdef REGFILE_BYPASS_EN
   logic a3_is_reg;

   always_comb begin
      a3_is_reg = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (A3 == ADDR_W'(i)) a3_is_reg = 1'b1;
      end
   end
`endif

   // Read muxes. Addresses are matched against each stored index so that
   // gap addresses fall through to zero without an out-of-range array index.
   always_comb begin
      rd1_next = '0;
      rd2_next = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (A1 == ADDR_W'(i)) rd1_next = regs[i];
         if (A2 == ADDR_W'(i)) rd2_next = regs[i];
      end
      if (A1 == PC_IDX) rd1_next = R15;
      if (A2 == PC_IDX) rd2_next = R15;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && a3_is_reg && (A1 == A3)) rd1_next = WD3;
      if (wr_en && a3_is_reg && (A2 == A3)) rd2_next = WD3;
`endif
   end

   // Register array: no reset, zeroed one entry per cycle while in CLEAR.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (state == CLEAR) begin
            if (cnt == ADDR_W'(i)) regs[i] <= '0;
         end else if (wr_en && (A3 == ADDR_W'(i))) begin
            regs[i] <= WD3;
         end
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         cnt       <= '0;
         RD1       <= '0;
         RD2       <= '0;
         pc_we     <= 1'b0;
         pc_wd     <= '0;
         flags_out <= '0;
         ready     <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               RD1   <= '0;
               RD2   <= '0;
               pc_we <= 1'b0;
               // The final clear edge also raises ready; accesses presented
               // on it are still treated as CLEAR-state accesses.
               if (cnt == LAST_CNT) begin
                  state <= READY;
                  ready <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            READY: begin
               if (clr_req) begin
                  state     <= CLEAR;
                  cnt       <= '0;
                  flags_out <= '0;
                  ready     <= 1'b0;
                  RD1       <= '0;
                  RD2       <= '0;
                  pc_we     <= 1'b0;
               end else begin
                  RD1   <= rd1_next;
                  RD2   <= rd2_next;
                  pc_we <= pc_wr;
                  if (pc_wr)    pc_wd     <= WD3;
                  if (flags_we) flags_out <= flags_in;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

   // Main DUT: default parameters (32-bit, 15 registers, PC_IDX = 15).
   logic        clk;
   logic        rst;
   logic        clr_req;
   logic [3:0]  a1, a2, a3;
   logic [31:0] wd3;
   logic        we3;
   logic [31:0] r15;
   logic        flags_we;
   logic [3:0]  flags_in;
   logic [31:0] rd1, rd2;
   logic        pc_we;
   logic [31:0] pc_wd;
   logic [3:0]  flags_out;
   logic        ready;

   // Small DUT: 16-bit, 10 registers, so addresses 10..14 form a gap.
   logic        s_clr_req;
   logic [3:0]  s_a1, s_a2, s_a3;
   logic [15:0] s_wd3;
   logic        s_we3;
   logic [15:0] s_r15;
   logic        s_flags_we;
   logic [3:0]  s_flags_in;
   logic [15:0] s_rd1, s_rd2;
   logic        s_pc_we;
   logic [15:0] s_pc_wd;
   logic [3:0]  s_flags_out;
   logic        s_ready;

   param_register_file u_dut (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3), .R15(r15),
      .flags_we(flags_we), .flags_in(flags_in),
      .RD1(rd1), .RD2(rd2), .pc_we(pc_we), .pc_wd(pc_wd),
      .flags_out(flags_out), .ready(ready)
   );

   param_register_file #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(10)) u_small (
      .clk(clk), .rst(rst), .clr_req(s_clr_req),
      .A1(s_a1), .A2(s_a2), .A3(s_a3), .WD3(s_wd3), .WE3(s_we3), .R15(s_r15),
      .flags_we(s_flags_we), .flags_in(s_flags_in),
      .RD1(s_rd1), .RD2(s_rd2), .pc_we(s_pc_we), .pc_wd(s_pc_wd),
      .flags_out(s_flags_out), .ready(s_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      clr_req  = 1'b0;
      we3      = 1'b0;
      a3       = 4'd0;
      wd3      = 32'h0;
      flags_we = 1'b0;
      flags_in = 4'h0;
   endtask

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] SAME_EDGE = 32'h22;
`else
   localparam logic [31:0] SAME_EDGE = 32'h11;
`endif

   typedef struct {
      logic        we3;
      logic [3:0]  a3;
      logic [31:0] wd3;
      logic [3:0]  a1;
      logic [3:0]  a2;
      logic [31:0] r15;
      logic        fwe;
      logic [3:0]  fin;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_pcwe;
      logic [31:0] e_pcwd;
      logic [3:0]  e_flags;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Vectors applied in READY, one edge each, results checked after the edge.
      //             we3  a3    wd3           a1    a2    r15         fwe   fin    rd1           rd2           pcwe  pcwd        flags
      vecs[0]  = '{1'b0, 4'd0,  32'h0,        4'd0, 4'd14, 32'h0,     1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0,      4'h0};
      vecs[1]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'd0, 4'd15, 32'h108,   1'b0, 4'h0, 32'h0,        32'h108,      1'b0, 32'h0,      4'h0};
      vecs[2]  = '{1'b0, 4'd0,  32'h0,        4'd3, 4'd15, 32'h10C,   1'b0, 4'h0, 32'hDEADBEEF, 32'h10C,      1'b0, 32'h0,      4'h0};
      vecs[3]  = '{1'b1, 4'd15, 32'h200,      4'd15, 4'd3, 32'h110,   1'b0, 4'h0, 32'h110,      32'hDEADBEEF, 1'b1, 32'h200,    4'h0};
      vecs[4]  = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd3, 32'h114,   1'b0, 4'h0, 32'h114,      32'hDEADBEEF, 1'b0, 32'h200,    4'h0};
      vecs[5]  = '{1'b1, 4'd14, 32'hA5A5,     4'd0, 4'd13, 32'h0,     1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h200,    4'h0};
      vecs[6]  = '{1'b0, 4'd0,  32'h0,        4'd14, 4'd0, 32'h0,     1'b0, 4'h0, 32'hA5A5,     32'h0,        1'b0, 32'h200,    4'h0};
      vecs[7]  = '{1'b0, 4'd0,  32'h0,        4'd3, 4'd14, 32'h0,     1'b1, 4'hA, 32'hDEADBEEF, 32'hA5A5,     1'b0, 32'h200,    4'hA};
      vecs[8]  = '{1'b1, 4'd5,  32'h11,       4'd0, 4'd0,  32'h0,     1'b0, 4'h3, 32'h0,        32'h0,        1'b0, 32'h200,    4'hA};
      vecs[9]  = '{1'b1, 4'd5,  32'h22,       4'd5, 4'd5,  32'h0,     1'b0, 4'h0, SAME_EDGE,    SAME_EDGE,    1'b0, 32'h200,    4'hA};
      vecs[10] = '{1'b0, 4'd0,  32'h0,        4'd5, 4'd15, 32'h120,   1'b0, 4'h5, 32'h22,       32'h120,      1'b0, 32'h200,    4'hA};
      vecs[11] = '{1'b0, 4'd0,  32'h0,        4'd5, 4'd3,  32'h0,     1'b1, 4'hA, 32'h22,       32'hDEADBEEF, 1'b0, 32'h200,    4'hA};

      // ---- power-on reset ----
      idle();
      a1 = 4'd0; a2 = 4'd14; r15 = 32'h0;
      s_clr_req = 1'b0; s_a1 = 4'd0; s_a2 = 4'd0; s_a3 = 4'd0; s_wd3 = 16'h0;
      s_we3 = 1'b0; s_r15 = 16'h0; s_flags_we = 1'b0; s_flags_in = 4'h0;
      rst = 1'b1;
      #2;
      chk("rst.ready", 32'(ready), 32'h0);
      chk("rst.rd1", rd1, 32'h0);
      chk("rst.rd2", rd2, 32'h0);
      chk("rst.pc_we", 32'(pc_we), 32'h0);
      chk("rst.pc_wd", pc_wd, 32'h0);
      chk("rst.flags", 32'(flags_out), 32'h0);
      step();
      step();
      rst = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         chk($sformatf("init.ready.e%0d", i), 32'(ready), (i == 15) ? 32'h1 : 32'h0);
         chk($sformatf("init.rd1.e%0d", i), rd1, 32'h0);
         chk($sformatf("init.rd2.e%0d", i), rd2, 32'h0);
         chk($sformatf("small.init.ready.e%0d", i), 32'(s_ready), (i >= 10) ? 32'h1 : 32'h0);
      end

      // ---- table-driven READY traffic ----
      for (int i = 0; i < 12; i++) begin
         we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
         a1 = vecs[i].a1; a2 = vecs[i].a2; r15 = vecs[i].r15;
         flags_we = vecs[i].fwe; flags_in = vecs[i].fin;
         step();
         chk($sformatf("v%0d.rd1", i), rd1, vecs[i].e_rd1);
         chk($sformatf("v%0d.rd2", i), rd2, vecs[i].e_rd2);
         chk($sformatf("v%0d.pc_we", i), 32'(pc_we), 32'(vecs[i].e_pcwe));
         chk($sformatf("v%0d.pc_wd", i), pc_wd, vecs[i].e_pcwd);
         chk($sformatf("v%0d.flags", i), 32'(flags_out), 32'(vecs[i].e_flags));
         chk($sformatf("v%0d.ready", i), 32'(ready), 32'h1);
      end

      // ---- soft clear: accesses and a second clr_req ignored in CLEAR ----
      idle();
      a1 = 4'd0; a2 = 4'd0;
      clr_req = 1'b1;
      step();
      chk("clr.enter.ready", 32'(ready), 32'h0);
      chk("clr.enter.flags", 32'(flags_out), 32'h0);
      for (int i = 1; i <= 15; i++) begin
         clr_req  = (i == 5);
         we3      = 1'b1;
         a3       = (i == 15) ? 4'd14 : (((i % 2) != 0) ? 4'd15 : 4'd5);
         wd3      = 32'h99;
         flags_we = 1'b1;
         flags_in = 4'hF;
         a1 = 4'd5; a2 = 4'd15; r15 = 32'h300;
         step();
         chk($sformatf("clr.ready.e%0d", i), 32'(ready), (i == 15) ? 32'h1 : 32'h0);
         chk($sformatf("clr.rd1.e%0d", i), rd1, 32'h0);
         chk($sformatf("clr.rd2.e%0d", i), rd2, 32'h0);
         chk($sformatf("clr.pc_we.e%0d", i), 32'(pc_we), 32'h0);
         chk($sformatf("clr.pc_wd.e%0d", i), pc_wd, 32'h200);
         chk($sformatf("clr.flags.e%0d", i), 32'(flags_out), 32'h0);
      end
      idle();
      a1 = 4'd5; a2 = 4'd3;
      step();
      chk("post_clr.r5", rd1, 32'h0);
      chk("post_clr.r3", rd2, 32'h0);
      chk("post_clr.flags", 32'(flags_out), 32'h0);
      chk("post_clr.ready", 32'(ready), 32'h1);
      a1 = 4'd14; a2 = 4'd15; r15 = 32'h304;
      step();
      chk("post_clr.r14", rd1, 32'h0);
      chk("post_clr.pc_read", rd2, 32'h304);

      // ---- small instance: gap addresses between NUM_REGS and PC_IDX ----
      s_we3 = 1'b1; s_a3 = 4'd10; s_wd3 = 16'h1234;
      step();
      chk("small.gap_wr.pc_we", 32'(s_pc_we), 32'h0);
      s_a3 = 4'd9; s_wd3 = 16'h0055;
      step();
      s_we3 = 1'b0; s_a1 = 4'd10; s_a2 = 4'd9;
      step();
      chk("small.gap_rd", 32'(s_rd1), 32'h0);
      chk("small.r9", 32'(s_rd2), 32'h55);
      s_a1 = 4'd15; s_a2 = 4'd12; s_r15 = 16'hBEEF;
      step();
      chk("small.pc_read", 32'(s_rd1), 32'hBEEF);
      chk("small.gap12", 32'(s_rd2), 32'h0);
      chk("small.pc_wd", 32'(s_pc_wd), 32'h0);
      chk("small.flags", 32'(s_flags_out), 32'h0);

      // ---- reset in the middle of CLEAR (cnt = 7) ----
      idle();
      we3 = 1'b1; a3 = 4'd13; wd3 = 32'h77;
      step();
      idle();
      a1 = 4'd13;
      step();
      chk("rst_mid.r13_before", rd1, 32'h77);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (7) step();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid.ready", 32'(ready), 32'h0);
      chk("rst_mid.pc_wd", pc_wd, 32'h0);
      chk("rst_mid.rd1", rd1, 32'h0);
      chk("rst_mid.pc_we", 32'(pc_we), 32'h0);
      step();
      step();
      rst = 1'b0;
      a1 = 4'd13; a2 = 4'd15; r15 = 32'h400;
      for (int i = 1; i <= 15; i++) begin
         step();
         chk($sformatf("rst_mid.ready.e%0d", i), 32'(ready), (i == 15) ? 32'h1 : 32'h0);
      end
      step();
      chk("rst_mid.r13_after", rd1, 32'h0);
      chk("rst_mid.pc_read", rd2, 32'h400);
      chk("rst_mid.pc_wd_after", pc_wd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
